// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write engine: FSM states,
// frame geometry and the codec's default slave address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam int FRAME_W        = 24;
  localparam int BYTES          = 3;
  localparam int PHASES_PER_BIT = 4;
  localparam int SLOTS_PER_BYTE = 9;

  localparam logic [7:0] WM8731_ADDR_W = 8'h34;

endpackage

// File: rtl/i2c_write_engine_if.sv
// Sequencer-facing request/response bundle of the I2C write engine,
// plus the FSM state exposed for observation.
interface i2c_write_engine_if;
  import i2c_pkg::*;

  logic [FRAME_W-1:0] i2c_data;
  logic               go;
  logic               frame_end;
  logic [BYTES-1:0]   ack;
  logic               busy;
  state_t             dbg_state;

  // go is a level request: the master holds it with i2c_data until it sees
  // frame_end, then drops it. frame_end stays high until go is sampled low,
  // or for exactly one cycle when go had already fallen mid-frame.
  modport master (output i2c_data, go,
                  input  frame_end, ack, busy, dbg_state);
  modport slave  (input  i2c_data, go,
                  output frame_end, ack, busy, dbg_state);

endinterface

// File: rtl/i2c_quarter_tick.sv
// Phase-advance enable: one pulse every QDIV clocks, restarted by clear so
// the first phase of a frame is always full length.
module i2c_quarter_tick #(
  parameter int QDIV = 1
) (
  input  logic clk_i2c,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(QDIV - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i2c) begin
    if (reset || clear || tick) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/i2c_write_engine.sv
// Bit-level I2C write master: START, three bytes each followed by an ACK
// slot, STOP. Bus pins are registered copies of the current phase.
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter int QDIV = 1
) (
  input  logic               clk_i2c,
  input  logic               reset,
  i2c_write_engine_if.slave  ctl,
  output logic               I2C_SCLK,
  inout  wire                I2C_SDAT
);

  localparam logic [1:0] LAST_Q    = 2'(PHASES_PER_BIT - 1);
  localparam logic [3:0] ACK_SLOT  = 4'(SLOTS_PER_BYTE - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);

  state_t             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [3:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BYTES-1:0]   ack_q, ack_d;
  logic               accept;
  logic               tick;
  logic               sda_in;

  logic scl_d, oe_d;
  logic scl_q, oe_q, end_q, busy_q;

  i2c_quarter_tick #(.QDIV(QDIV)) u_tick (
    .clk_i2c (clk_i2c),
    .reset   (reset),
    .clear   ((state_q == ST_IDLE) || (state_q == ST_DONE)),
    .tick    (tick)
  );

  assign sda_in = I2C_SDAT;

  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= 2'd0;
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      sr_q    <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sr_q    <= sr_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sr_d    = sr_q;
    ack_d   = ack_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctl.go && !end_q) begin
          accept  = 1'b1;
          state_d = ST_START;
          phase_d = 2'd0;
          bit_d   = 4'd0;
          byte_d  = 2'd0;
          sr_d    = ctl.i2c_data;
          ack_d   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (phase_q == 2'd1) begin
            state_d = ST_BIT;
            phase_d = 2'd0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      ST_BIT: begin
        if (tick) begin
          // Sample on the last clock of q2 in the ACK slot; byte 0 lands in ack[2].
          if (bit_q == ACK_SLOT && phase_q == 2'd2) begin
            case (byte_q)
              2'd0:    ack_d[2] = sda_in;
              2'd1:    ack_d[1] = sda_in;
              default: ack_d[0] = sda_in;
            endcase
          end
          if (phase_q == LAST_Q) begin
            phase_d = 2'd0;
            if (bit_q == ACK_SLOT) begin
              bit_d = 4'd0;
              if (byte_q == LAST_BYTE) begin
                state_d = ST_STOP;
                byte_d  = 2'd0;
              end else begin
                byte_d = byte_q + 2'd1;
              end
            end else begin
              bit_d = bit_q + 4'd1;
              sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (phase_q == 2'd2) begin
            state_d = ST_DONE;
            phase_d = 2'd0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        if (!ctl.go) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus levels for the current phase; oe=1 pulls SDA low, oe=0 releases it.
  always_comb begin
    scl_d = 1'b1;
    oe_d  = 1'b0;
    case (state_q)
      ST_START: begin
        scl_d = (phase_q == 2'd0);
        oe_d  = 1'b1;
      end
      ST_BIT: begin
        scl_d = phase_q[1];
        oe_d  = (bit_q != ACK_SLOT) && !sr_q[FRAME_W-1];
      end
      ST_STOP: begin
        scl_d = (phase_q != 2'd0);
        oe_d  = (phase_q != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      scl_q  <= 1'b1;
      oe_q   <= 1'b0;
      end_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      scl_q <= scl_d;
      oe_q  <= oe_d;
      // A go that fell mid-frame still earns a single cycle of end.
      end_q <= (state_q == ST_DONE) && (ctl.go || !end_q);
      if (accept) begin
        busy_q <= 1'b1;
      end else if (state_q == ST_DONE) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign I2C_SCLK      = scl_q;
  assign I2C_SDAT      = oe_q ? 1'b0 : 1'bz;
  assign ctl.frame_end = end_q;
  assign ctl.ack       = ack_q;
  assign ctl.busy      = busy_q;
  assign ctl.dbg_state = state_q;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Directed bench for i2c_write_engine: bus decoder plus ACK-ing slave on the
// QDIV=1 instance, timing checks on a QDIV=3 instance.
module tb_i2c_write_engine;
  import i2c_pkg::*;

  // clock / reset
  logic clk_i2c = 1'b0;
  logic reset;
  always #5 clk_i2c = ~clk_i2c;

  i2c_write_engine_if bus1();
  i2c_write_engine_if bus3();
  logic scl1, scl3;
  wire  sda1, sda3;
  pullup pu1 (sda1);
  pullup pu3 (sda3);

  logic slave_low = 1'b0;
  assign sda1 = slave_low ? 1'b0 : 1'bz;

  i2c_write_engine #(.QDIV(1)) dut1 (
    .clk_i2c (clk_i2c), .reset (reset), .ctl (bus1),
    .I2C_SCLK (scl1), .I2C_SDAT (sda1)
  );
  i2c_write_engine #(.QDIV(3)) dut3 (
    .clk_i2c (clk_i2c), .reset (reset), .ctl (bus3),
    .I2C_SCLK (scl3), .I2C_SDAT (sda3)
  );

  // scoreboard
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int passed = 0, total = 0, failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // bus decoder and slave model for dut1, sampled away from the active edge
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [8:0] shreg = '0;
  logic [2:0] nack_mask;
  int rise_cnt = 0, start_cnt = 0, stop_cnt = 0, overlap_err = 0;
  int in_frame = 0, mon_req = 0, mon_ack = 0;

  always @(negedge clk_i2c) begin
    if (mon_req != mon_ack) begin
      mon_ack   = mon_req;
      in_frame  = 0;
      rise_cnt  = 0;
      slave_low = 1'b0;
    end else if (prev_scl && scl1 && prev_sda && !sda1) begin
      if (in_frame != 0) overlap_err++;
      in_frame = 1;
      start_cnt++;
      rise_cnt = 0;
      got_q.delete();
    end else if (prev_scl && scl1 && !prev_sda && sda1) begin
      if (in_frame != 0) stop_cnt++;
      in_frame = 0;
    end else if (!prev_scl && scl1 && in_frame != 0) begin
      shreg = {shreg[7:0], sda1};
      rise_cnt++;
      if (rise_cnt % 9 == 0) got_q.push_back(shreg);
    end else if (prev_scl && !scl1 && in_frame != 0) begin
      slave_low = (rise_cnt % 9 == 8) && !nack_mask[2 - rise_cnt / 9];
    end
    prev_scl = scl1;
    prev_sda = sda1;
  end

  // end must not outlive go by more than one cycle while tracking is on
  int go_low_cycles = 0, end_go_err = 0;
  logic track_end = 1'b0;
  always @(negedge clk_i2c) begin
    if (bus1.go) go_low_cycles = 0;
    else go_low_cycles++;
    if (track_end && bus1.frame_end && go_low_cycles > 1) end_go_err++;
  end

  // SCL run lengths on dut3
  int   run_len3 = 0;
  int   runs3[$];
  logic prev_scl3 = 1'b1;
  always @(negedge clk_i2c) begin
    if (scl3 !== prev_scl3) begin
      runs3.push_back(run_len3);
      run_len3 = 1;
    end else begin
      run_len3++;
    end
    prev_scl3 = scl3;
  end

  // driver tasks
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk_i2c);
    #1;
  endtask

  task automatic expect_frame(input logic [23:0] data, input logic [2:0] mask);
    exp_q.delete();
    exp_q.push_back({data[23:16], mask[2]});
    exp_q.push_back({data[15:8],  mask[1]});
    exp_q.push_back({data[7:0],   mask[0]});
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nbytes"}, got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  // Called #1 after an edge: go is accepted on the next edge (k).
  task automatic run_frame(input string tag, input logic [23:0] data,
                           input logic [2:0] mask, output int lat);
    nack_mask = mask;
    expect_frame(data, mask);
    bus1.i2c_data = data;
    bus1.go = 1'b1;
    @(posedge clk_i2c); #1;
    check({tag, "_busy"}, bus1.busy, 1);
    check({tag, "_state_start"}, bus1.dbg_state, ST_START);
    lat = 0;
    while (!bus1.frame_end && lat < 2000) begin
      @(posedge clk_i2c); #1;
      lat++;
    end
    check({tag, "_ack"}, bus1.ack, mask);
    check({tag, "_busy_at_end"}, bus1.busy, 0);
    check_frame(tag);
    bus1.go = 1'b0;
    tick_n(1);
    check({tag, "_end_fell"}, bus1.frame_end, 0);
    check({tag, "_idle"}, bus1.dbg_state, ST_IDLE);
  endtask

  logic [23:0] seq_frames [9];
  int lat, n, high_n, sc, st, nb, bad;

  initial begin
    reset = 1'b1;
    bus1.go = 1'b0; bus1.i2c_data = '0;
    bus3.go = 1'b0; bus3.i2c_data = '0;
    nack_mask = 3'b000;
    seq_frames[0] = {WM8731_ADDR_W, 16'h1E00};
    seq_frames[1] = {WM8731_ADDR_W, 16'h0017};
    seq_frames[2] = {WM8731_ADDR_W, 16'h0217};
    seq_frames[3] = {WM8731_ADDR_W, 16'h0479};
    seq_frames[4] = {WM8731_ADDR_W, 16'h0679};
    seq_frames[5] = {WM8731_ADDR_W, 16'h0812};
    seq_frames[6] = {WM8731_ADDR_W, 16'h0A00};
    seq_frames[7] = {WM8731_ADDR_W, 16'h0C00};
    seq_frames[8] = {WM8731_ADDR_W, 16'h1201};
    tick_n(3);

    check("rst_scl", scl1, 1);
    check("rst_sda", sda1, 1);
    check("rst_end", bus1.frame_end, 0);
    check("rst_busy", bus1.busy, 0);
    check("rst_ack", bus1.ack, 0);
    check("rst_state", bus1.dbg_state, ST_IDLE);
    reset = 1'b0;
    tick_n(2);

    // acked write
    run_frame("acked", 24'h341E00, 3'b000, lat);
    check("acked_latency", lat, 114);
    tick_n(3);

    // data-byte NACK still completes with STOP
    st = stop_cnt;
    run_frame("nack", 24'h340274, 3'b001, lat);
    check("nack_latency", lat, 114);
    check("nack_stop", stop_cnt - st, 1);
    tick_n(3);

    // back-to-back sequencer frames
    sc = start_cnt; st = stop_cnt;
    track_end = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("b2b%0d", i), seq_frames[i], 3'b000, lat);
      tick_n(1);
    end
    track_end = 1'b0;
    check("b2b_starts", start_cnt - sc, 9);
    check("b2b_stops", stop_cnt - st, 9);
    check("b2b_overlap", overlap_err, 0);
    check("b2b_end_vs_go", end_go_err, 0);
    tick_n(3);

    // go dropped mid-frame; later data changes must be ignored
    sc = start_cnt;
    nack_mask = 3'b000;
    expect_frame(24'h341201, 3'b000);
    bus1.i2c_data = 24'h341201;
    bus1.go = 1'b1;
    tick_n(10);
    bus1.go = 1'b0;
    bus1.i2c_data = 24'hFFFFFF;
    n = 0;
    while (!bus1.frame_end && n < 2000) begin
      tick_n(1);
      n++;
    end
    check("drop_end_seen", bus1.frame_end, 1);
    high_n = 0;
    while (bus1.frame_end && high_n < 10) begin
      tick_n(1);
      high_n++;
    end
    check("drop_end_width", high_n, 1);
    check_frame("drop");
    tick_n(150);
    check("drop_no_retrigger", start_cnt - sc, 1);
    check("drop_idle", bus1.dbg_state, ST_IDLE);
    check("drop_busy", bus1.busy, 0);

    // reset at phase 40
    bus1.i2c_data = 24'h341E55;
    bus1.go = 1'b1;
    @(posedge clk_i2c);
    tick_n(40);
    reset = 1'b1;
    bus1.go = 1'b0;
    mon_req++;
    tick_n(1);
    check("midrst_scl", scl1, 1);
    check("midrst_sda", sda1, 1);
    check("midrst_busy", bus1.busy, 0);
    check("midrst_end", bus1.frame_end, 0);
    check("midrst_state", bus1.dbg_state, ST_IDLE);
    reset = 1'b0;
    tick_n(2);
    sc = start_cnt; st = stop_cnt;
    run_frame("postrst", 24'h340C00, 3'b000, lat);
    check("postrst_latency", lat, 114);
    check("postrst_startstop", (start_cnt - sc) * 16 + (stop_cnt - st), 17);
    tick_n(3);

    // QDIV=3, no slave on this bus so every ACK slot reads released
    nb = runs3.size();
    bus3.i2c_data = 24'h341E00;
    bus3.go = 1'b1;
    @(posedge clk_i2c); #1;
    check("q3_busy", bus3.busy, 1);
    lat = 0;
    while (!bus3.frame_end && lat < 4000) begin
      @(posedge clk_i2c); #1;
      lat++;
    end
    check("q3_latency", lat, 340);
    check("q3_ack", bus3.ack, 3'b111);
    check("q3_nruns", runs3.size() >= nb + 56, 1);
    check("q3_first_low", runs3[nb + 1], 9);
    bad = 0;
    for (int i = 2; i <= 54; i++) begin
      if (runs3[nb + i] != 6) bad++;
    end
    check("q3_halves_6", bad, 0);
    check("q3_stop_p0", runs3[nb + 55], 3);
    bus3.go = 1'b0;
    tick_n(2);
    check("q3_end_fell", bus3.frame_end, 0);
    check("q3_idle", bus3.dbg_state, ST_IDLE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_write_engine.md
# i2c_write_engine

Bit-level I2C write master sitting directly downstream of the audio-codec configuration sequencer. It accepts one 24-bit frame {slave address byte, register byte, data byte} under a level GO/END handshake and serialises it onto the open-drain I2C bus. The sequence is START, three bytes each followed by an ACK slot, then STOP. The three sampled ACK bits are reported back for the sequencer to check.

## Interface
- QDIV, default 1: clk_i2c cycles per quarter-bit phase; legal range 1–255.
- clk_i2c  in  1  I2C work clock (10 kHz); only clock in the block.
- reset  in  1  synchronous, active-high reset.
- i2c_data  in  24  frame to send. [23:16] slave address plus R/W̄ bit (always 0), [15:8] register byte, [7:0] data byte. MSB is sent first.
- go  in  1  level request. The sequencer holds it high until end is seen, then drops it.
- end  out  1  transaction complete; stays high until go is low.
- ack  out  3  sampled SDA in ACK slots. [2] is the address byte, [1] the register byte, [0] the data byte. 0 means acknowledged.
- busy  out  1  high from acceptance of go until end rises.
- I2C_SCLK  out  1  bus clock, push-pull.
- I2C_SDAT  inout  1  bus data, open-drain: drives 0 or Z only. The block reads the pin directly and treats Z as 1 through the external pull-up.

## Operation
- **States:** IDLE, START, BIT, STOP, DONE.
- **IDLE**
  - SCLK=1, SDAT=Z, end=0.
  - When go=1 (and end=0): latch i2c_data into the shift register, clear ack to 3'b000, set busy=1, go to START.
- **START:** two phases.
  - S0: SCLK=1, SDAT=0. This is the START condition.
  - S1: SCLK=0, SDAT=0.
- **BIT:** 27 slots, 3 bytes × (8 data + 1 ACK), each slot four phases.
  - q0: SCLK=0; SDAT updated to the shift-register MSB (0 → drive 0, 1 → Z). In an ACK slot SDAT is Z.
  - q1: SCLK=0.
  - q2: SCLK=1. In an ACK slot, SDA is sampled into the ack bit for that byte on the last clock of q2.
  - q3: SCLK=1.
  - Shift register shifts left at the end of q3 of each data slot.
- **Counters:** 2-bit phase counter, 4-bit bit counter (0–8), 2-bit byte counter (0–2).
- **STOP:** three phases.
  - P0: SCLK=0, SDAT=0.
  - P1: SCLK=1, SDAT=0.
  - P2: SCLK=1, SDAT=Z. This is the STOP condition.
- **DONE**
  - end=1, busy=0.
  - When go=0: end=0 and return to IDLE.
  - If go is still 1, stay in DONE. No retrigger is possible without go first going low.
- **NACK handling:** a NACK does not abort. The frame always completes, and ack carries the raw sampled levels.
- **Input stability:** i2c_data and go changes after acceptance are ignored until DONE.
  - If go drops mid-frame, the frame still completes. end is then high for exactly one clock and the block returns to IDLE.

## Timing
- **Phase length:** one phase = QDIV clk_i2c cycles. Total frame = 2 + 108 + 3 = 113 phases.
- **Latency:** go sampled high at edge k → START S0 visible from edge k+1 → end rises at edge k+1+113·QDIV.
  - For QDIV=1, end rises at edge k+114.
- **Reset values:** I2C_SCLK=1, I2C_SDAT=Z, end=0, busy=0, ack=3'b000, state=IDLE.
- **Reset mid-frame:** on the next edge the bus is released (SCLK=1, SDAT=Z) with no STOP generated, and all counters are cleared. The bus may be left mid-byte; recovery is the sequencer's next START.
- **Output registering:** all outputs are registered with no combinational path from inputs. SDAT changes only while SCLK=0, except at START S0 and STOP P2.
- **Handshake compatibility:** the sequencer drops go the cycle after seeing end and re-raises it at least 2 cycles later. The DONE→IDLE path costs one cycle, so back-to-back frames are gapless beyond that.

## Structure
- **Shared package i2c_pkg:**
  - state enum
  - FRAME_W=24, BYTES=3, PHASES_PER_BIT=4
  - WM8731_ADDR_W=8'h34
- **Sub-module i2c_quarter_tick:** a QDIV divider producing a one-cycle phase-advance enable. It is always 1 when QDIV=1. The FSM advances only on this enable.
- **Size:** the FSM, shift register and ack capture fit in one module of about 200 lines.

## Test plan
- **Acked write:** i2c_data=24'h34_1E_00, QDIV=1, slave model ACKs all bytes.
  - Bus monitor decodes START, 0x34, A, 0x1E, A, 0x00, A, STOP.
  - end rises at edge k+114; ack=3'b000.
- **Data-byte NACK:** i2c_data=24'h34_02_74, slave NACKs the data byte.
  - Full frame and STOP still occur; ack=3'b001.
- **Back-to-back frames:** 9 frames driven with the sequencer's go/end protocol (go dropped on end, re-raised 2 cycles later).
  - 9 distinct START/STOP pairs, no overlap.
  - end never high while go has been low for more than 1 cycle.
- **go dropped mid-frame:** go held high for 10 cycles only.
  - Frame completes; end high exactly 1 cycle; returns to IDLE; no second frame.
- **Reset mid-frame:** reset asserted at phase 40.
  - SCLK=1, SDAT=Z, busy=0, end=0 on the next edge.
  - The next go produces a clean frame.
- **QDIV=3:** same frame as the acked write.
  - Each SCLK high/low half lasts 6 cycles; end rises at edge k+1+339.
